icache_miss_ctrl: RTL and testbench

//  Single-outstanding miss controller between icache F2 stage and L2. Sends line-fill requests to L2,

---
 rtl/icache_pkg.sv | 52 +++++
 rtl/icache_inv_unit.sv | 82 ++++++++
 rtl/icache_miss_ctrl.sv | 167 ++++++++++++++++
 tb/tb_icache_miss_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, op encodings, FSM state types and address-slice helpers
// for the icache miss controller and its invalidate unit.
package icache_pkg;

  localparam int SET_CNT    = 1024;
  localparam int INDEX_SZ   = $clog2(SET_CNT);
  localparam int CACHE_LINE = 512;
  localparam int OFFSET_SZ  = $clog2(CACHE_LINE);
  localparam int ADDR_SZ    = 32;
  localparam int TAG_SZ     = ADDR_SZ - OFFSET_SZ - INDEX_SZ;
  localparam int WAYS       = 4;
  localparam int WAY_SZ     = $clog2(WAYS);
  localparam int TIMEOUT    = 255;
  localparam int TIMER_SZ   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] L2_READ_LINE = 3'b001;
  localparam logic [2:0] RSP_FILL     = 3'b001;
  localparam logic [2:0] RSP_INVAL    = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } miss_state_t;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_LOOK = 2'd1,
    I_WR   = 2'd2
  } inv_state_t;

  function automatic logic [INDEX_SZ-1:0] addr_index(input logic [ADDR_SZ-1:0] a);
    return a[OFFSET_SZ +: INDEX_SZ];
  endfunction

  function automatic logic [TAG_SZ-1:0] addr_tag(input logic [ADDR_SZ-1:0] a);
    return a[ADDR_SZ-1 -: TAG_SZ];
  endfunction

  function automatic logic [ADDR_SZ-1:0] line_addr(input logic [ADDR_SZ-1:0] a);
    return {a[ADDR_SZ-1:OFFSET_SZ], {OFFSET_SZ{1'b0}}};
  endfunction

  function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_SZ-1:0] w);
    logic [WAYS-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/icache_inv_unit.sv
// L2 invalidate handler: looks up the tags of one set, then clears the valid
// bit of every way whose valid tag matches the invalidated line.
module icache_inv_unit
  import icache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [INDEX_SZ-1:0]      inv_set,
  input  logic [TAG_SZ-1:0]        inv_tag,
  input  logic [TAG_SZ*WAYS-1:0]   rd_tags,
  input  logic [WAYS-1:0]          rd_vld,
  output logic                     idle,
  output logic                     rd_en,
  output logic [INDEX_SZ-1:0]      rd_set,
  output logic                     wr_en,
  output logic [WAYS-1:0]          wr_way,
  output logic [INDEX_SZ-1:0]      wr_set,
  output logic [TAG_SZ-1:0]        wr_tag
);

  inv_state_t          state_reg, state_next;
  logic [INDEX_SZ-1:0] set_reg, set_next;
  logic [TAG_SZ-1:0]   tag_reg, tag_next;
  logic [WAYS-1:0]     hit_mask;

  // Tags are only meaningful in I_WR, the cycle after the lookup.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
    assign hit_mask[gi] = rd_vld[gi] && (rd_tags[gi*TAG_SZ +: TAG_SZ] == tag_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= I_IDLE;
      set_reg   <= '0;
      tag_reg   <= '0;
    end else begin
      state_reg <= state_next;
      set_reg   <= set_next;
      tag_reg   <= tag_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    set_next   = set_reg;
    tag_next   = tag_reg;
    idle       = 1'b0;
    rd_en      = 1'b0;
    rd_set     = '0;
    wr_en      = 1'b0;
    wr_way     = '0;
    wr_set     = '0;
    wr_tag     = '0;
    case (state_reg)
      I_IDLE: begin
        idle = 1'b1;
        if (start) begin
          set_next   = inv_set;
          tag_next   = inv_tag;
          state_next = I_LOOK;
        end
      end
      I_LOOK: begin
        rd_en      = 1'b1;
        rd_set     = set_reg;
        state_next = I_WR;
      end
      I_WR: begin
        if (|hit_mask) begin
          wr_en  = 1'b1;
          wr_way = hit_mask;
          wr_set = set_reg;
          wr_tag = tag_reg;
        end
        state_next = I_IDLE;
      end
      default: state_next = I_IDLE;
    endcase
  end

endmodule

// File: rtl/icache_miss_ctrl.sv
// Single-outstanding icache miss controller: issues L2 line reads, writes
// returned lines, and shares the array write port with the invalidate unit.
module icache_miss_ctrl
  import icache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [ADDR_SZ-1:0]       miss_paddr,
  input  logic [WAY_SZ-1:0]        miss_way,
  input  logic                     kill,
  output logic                     l2_req_valid,
  input  logic                     l2_req_ready,
  output logic [2:0]               l2_req_op,
  output logic [ADDR_SZ-1:0]       l2_req_addr,
  input  logic                     l2_rsp_valid,
  output logic                     l2_rsp_ready,
  input  logic [2:0]               l2_rsp_op,
  input  logic [ADDR_SZ-1:0]       l2_rsp_addr,
  input  logic [CACHE_LINE-1:0]    l2_rsp_data,
  output logic                     arr_rd_en,
  output logic [INDEX_SZ-1:0]      arr_rd_set,
  input  logic [TAG_SZ*WAYS-1:0]   arr_rd_tags,
  input  logic [WAYS-1:0]          arr_rd_vld,
  output logic                     arr_wr_en,
  output logic [INDEX_SZ-1:0]      arr_wr_set,
  output logic [WAYS-1:0]          arr_wr_way,
  output logic [TAG_SZ-1:0]        arr_wr_tag,
  output logic                     arr_wr_vld,
  output logic [CACHE_LINE-1:0]    arr_wr_data,
  output logic                     fill_done,
  output logic                     busy
);

  miss_state_t           state_reg, state_next;
  logic [ADDR_SZ-1:0]    paddr_reg, paddr_next;
  logic [WAY_SZ-1:0]     way_reg, way_next;
  logic                  kill_reg, kill_next;
  logic                  poison_reg, poison_next;
  logic [TIMER_SZ-1:0]   timer_reg, timer_next;
  logic [CACHE_LINE-1:0] data_reg, data_next;

  logic                  inv_idle;
  logic                  inv_wr_en;
  logic [WAYS-1:0]       inv_wr_way;
  logic [INDEX_SZ-1:0]   inv_wr_set;
  logic [TAG_SZ-1:0]     inv_wr_tag;

  logic                  rsp_fire;
  logic                  rsp_line_match;
  logic                  fill_hit;
  logic                  inval_fire;
  logic                  fill_wr;
  logic                  unused_offset_bits;

  // Responses only compare at line granularity; byte offsets carry no meaning.
  assign unused_offset_bits = ^{miss_paddr[OFFSET_SZ-1:0], l2_rsp_addr[OFFSET_SZ-1:0]};

  // Holding off responses during FILL keeps fill and invalidate writes apart.
  assign l2_rsp_ready   = inv_idle && (state_reg != FILL);
  assign rsp_fire       = l2_rsp_valid && l2_rsp_ready;
  assign rsp_line_match = (l2_rsp_addr[ADDR_SZ-1:OFFSET_SZ] == paddr_reg[ADDR_SZ-1:OFFSET_SZ]);
  assign fill_hit       = (state_reg == WAIT) && rsp_fire && (l2_rsp_op == RSP_FILL) && rsp_line_match;
  assign inval_fire     = rsp_fire && (l2_rsp_op == RSP_INVAL);

  icache_inv_unit u_inv (
    .clk     (clk),
    .rst     (rst),
    .start   (inval_fire),
    .inv_set (addr_index(l2_rsp_addr)),
    .inv_tag (addr_tag(l2_rsp_addr)),
    .rd_tags (arr_rd_tags),
    .rd_vld  (arr_rd_vld),
    .idle    (inv_idle),
    .rd_en   (arr_rd_en),
    .rd_set  (arr_rd_set),
    .wr_en   (inv_wr_en),
    .wr_way  (inv_wr_way),
    .wr_set  (inv_wr_set),
    .wr_tag  (inv_wr_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      paddr_reg  <= '0;
      way_reg    <= '0;
      kill_reg   <= 1'b0;
      poison_reg <= 1'b0;
      timer_reg  <= '0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      paddr_reg  <= paddr_next;
      way_reg    <= way_next;
      kill_reg   <= kill_next;
      poison_reg <= poison_next;
      timer_reg  <= timer_next;
      data_reg   <= data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    paddr_next   = paddr_reg;
    way_next     = way_reg;
    kill_next    = kill_reg;
    poison_next  = poison_reg;
    timer_next   = timer_reg;
    data_next    = data_reg;
    miss_ready   = 1'b0;
    l2_req_valid = 1'b0;
    fill_wr      = 1'b0;
    fill_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        miss_ready = inv_idle;
        if (miss_valid && inv_idle) begin
          state_next  = REQ;
          paddr_next  = line_addr(miss_paddr);
          way_next    = miss_way;
          kill_next   = 1'b0;
          poison_next = 1'b0;
          timer_next  = '0;
        end
      end
      REQ: begin
        l2_req_valid = 1'b1;
        if (l2_req_ready) state_next = WAIT;
      end
      WAIT: begin
        timer_next = timer_reg + 1'b1;
        if (fill_hit) begin
          state_next = FILL;
          data_next  = l2_rsp_data;
        end else if (timer_reg == TIMER_SZ'(TIMEOUT)) begin
          state_next = REQ;
          timer_next = '0;
        end
      end
      FILL: begin
        fill_wr    = 1'b1;
        fill_done  = ~kill_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A kill or a racing invalidate only matters while the line is in flight.
    if (state_reg == REQ || state_reg == WAIT) begin
      if (kill) kill_next = 1'b1;
      if (inval_fire && rsp_line_match) poison_next = 1'b1;
    end
  end

  assign l2_req_op   = l2_req_valid ? L2_READ_LINE : 3'b000;
  assign l2_req_addr = l2_req_valid ? paddr_reg : '0;
  assign busy        = (state_reg != IDLE);

  assign arr_wr_en   = fill_wr || inv_wr_en;
  assign arr_wr_set  = fill_wr ? addr_index(paddr_reg) : inv_wr_set;
  assign arr_wr_way  = fill_wr ? way_onehot(way_reg) : inv_wr_way;
  assign arr_wr_tag  = fill_wr ? addr_tag(paddr_reg) : inv_wr_tag;
  assign arr_wr_vld  = fill_wr && !poison_reg;
  assign arr_wr_data = fill_wr ? data_reg : '0;

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Directed plus randomized bench for icache_miss_ctrl with an array memory
// model and an address-arithmetic reference for expected writes.
module tb_icache_miss_ctrl;
  import icache_pkg::*;

  localparam int LIMIT = 2000;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   miss_valid = 1'b0;
  logic                   miss_ready;
  logic [ADDR_SZ-1:0]     miss_paddr = '0;
  logic [WAY_SZ-1:0]      miss_way = '0;
  logic                   kill = 1'b0;
  logic                   l2_req_valid;
  logic                   l2_req_ready = 1'b0;
  logic [2:0]             l2_req_op;
  logic [ADDR_SZ-1:0]     l2_req_addr;
  logic                   l2_rsp_valid = 1'b0;
  logic                   l2_rsp_ready;
  logic [2:0]             l2_rsp_op = '0;
  logic [ADDR_SZ-1:0]     l2_rsp_addr = '0;
  logic [CACHE_LINE-1:0]  l2_rsp_data = '0;
  logic                   arr_rd_en;
  logic [INDEX_SZ-1:0]    arr_rd_set;
  logic [TAG_SZ*WAYS-1:0] arr_rd_tags = '0;
  logic [WAYS-1:0]        arr_rd_vld = '0;
  logic                   arr_wr_en;
  logic [INDEX_SZ-1:0]    arr_wr_set;
  logic [WAYS-1:0]        arr_wr_way;
  logic [TAG_SZ-1:0]      arr_wr_tag;
  logic                   arr_wr_vld;
  logic [CACHE_LINE-1:0]  arr_wr_data;
  logic                   fill_done;
  logic                   busy;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int fill_cnt = 0;

  bit [TAG_SZ-1:0] mem_tag [SET_CNT][WAYS];
  bit              mem_vld [SET_CNT][WAYS];

  icache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_paddr(miss_paddr),
    .miss_way(miss_way), .kill(kill),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_op(l2_req_op),
    .l2_req_addr(l2_req_addr),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_ready(l2_rsp_ready), .l2_rsp_op(l2_rsp_op),
    .l2_rsp_addr(l2_rsp_addr), .l2_rsp_data(l2_rsp_data),
    .arr_rd_en(arr_rd_en), .arr_rd_set(arr_rd_set), .arr_rd_tags(arr_rd_tags),
    .arr_rd_vld(arr_rd_vld),
    .arr_wr_en(arr_wr_en), .arr_wr_set(arr_wr_set), .arr_wr_way(arr_wr_way),
    .arr_wr_tag(arr_wr_tag), .arr_wr_vld(arr_wr_vld), .arr_wr_data(arr_wr_data),
    .fill_done(fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Tag/data array model: reads return on the following cycle, writes land per way mask.
  always @(negedge clk) begin
    if (arr_rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        arr_rd_tags[w*TAG_SZ +: TAG_SZ] <= mem_tag[arr_rd_set][w];
        arr_rd_vld[w]                   <= mem_vld[arr_rd_set][w];
      end
    end
    if (arr_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      for (int w = 0; w < WAYS; w++) begin
        if (arr_wr_way[w]) begin
          mem_tag[arr_wr_set][w] <= arr_wr_tag;
          mem_vld[arr_wr_set][w] <= arr_wr_vld;
        end
      end
    end
    if (fill_done) fill_cnt <= fill_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_line(input logic [31:0] a);
    return a - (a % 512);
  endfunction
  function automatic logic [31:0] ref_set(input logic [31:0] a);
    return (a / 512) % 1024;
  endfunction
  function automatic logic [31:0] ref_tag(input logic [31:0] a);
    return a / (512 * 1024);
  endfunction
  function automatic logic [31:0] ref_mask(input logic [31:0] a);
    logic [31:0] m;
    int s;
    m = 0;
    s = int'(ref_set(a));
    for (int w = 0; w < WAYS; w++)
      if (mem_vld[s][w] && (32'(mem_tag[s][w]) == ref_tag(a))) m = m | (32'd1 << w);
    return m;
  endfunction
  function automatic logic [511:0] rnd_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [1:0] w, output int waited);
    int n;
    n = 0;
    miss_valid = 1'b1; miss_paddr = a; miss_way = w;
    while (!miss_ready && n < LIMIT) begin step(); n++; end
    chk("miss_accept_bound", 32'(n < LIMIT), 1);
    step();
    miss_valid = 1'b0;
    waited = n;
  endtask

  task automatic wait_req(input logic [31:0] line, input int rdly);
    int n;
    n = 0;
    while (!l2_req_valid && n < LIMIT) begin step(); n++; end
    chk("req_bound", 32'(n < LIMIT), 1);
    chk("req_addr", l2_req_addr, line);
    chk("req_op", 32'(l2_req_op), 1);
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("req_hold", 32'(l2_req_valid), 1);
    end
    l2_req_ready = 1'b1;
    step();
    l2_req_ready = 1'b0;
  endtask

  task automatic send_rsp(input logic [2:0] op, input logic [31:0] a, input logic [511:0] d);
    int n;
    n = 0;
    l2_rsp_valid = 1'b1; l2_rsp_op = op; l2_rsp_addr = a; l2_rsp_data = d;
    while (!l2_rsp_ready && n < LIMIT) begin step(); n++; end
    chk("rsp_accept_bound", 32'(n < LIMIT), 1);
    step();
    l2_rsp_valid = 1'b0;
  endtask

  task automatic do_inval(input logic [31:0] a);
    logic [31:0] emask;
    int n, wc0;
    n = 0;
    l2_rsp_valid = 1'b1; l2_rsp_op = RSP_INVAL; l2_rsp_addr = a; l2_rsp_data = rnd_line();
    while (!l2_rsp_ready && n < LIMIT) begin step(); n++; end
    chk("inval_accept_bound", 32'(n < LIMIT), 1);
    emask = ref_mask(a);
    wc0 = wr_cnt;
    step();
    l2_rsp_valid = 1'b0;
    chk("inval_rd_en", 32'(arr_rd_en), 1);
    chk("inval_rd_set", 32'(arr_rd_set), ref_set(a));
    chk("inval_look_no_wr", 32'(arr_wr_en), 0);
    chk("inval_look_rsp_ready", 32'(l2_rsp_ready), 0);
    chk("inval_look_miss_ready", 32'(miss_ready), 0);
    step();
    chk("inval_wr_en", 32'(arr_wr_en), 32'(emask != 0));
    if (emask != 0) begin
      chk("inval_wr_way", 32'(arr_wr_way), emask);
      chk("inval_wr_set", 32'(arr_wr_set), ref_set(a));
      chk("inval_wr_vld", 32'(arr_wr_vld), 0);
    end
    step();
    chk("inval_done_rsp_ready", 32'(l2_rsp_ready), 1);
    chk("inval_wr_count", wr_cnt, wc0 + 32'(emask != 0));
  endtask

  task automatic check_fill(input logic [31:0] a, input logic [1:0] w, input logic [511:0] d,
                            input bit ev, input bit ed);
    chk("fill_wr_en", 32'(arr_wr_en), 1);
    chk("fill_wr_set", 32'(arr_wr_set), ref_set(a));
    chk("fill_wr_way", 32'(arr_wr_way), 32'd1 << w);
    chk("fill_wr_tag", 32'(arr_wr_tag), ref_tag(a));
    chk("fill_wr_vld", 32'(arr_wr_vld), 32'(ev));
    chkd("fill_wr_data", arr_wr_data, d);
    chk("fill_done", 32'(fill_done), 32'(ed));
    chk("fill_rsp_ready", 32'(l2_rsp_ready), 0);
  endtask

  task automatic full_miss(input logic [31:0] a, input logic [1:0] w, input int rdly, input int lat,
                           input bit kill_it, input bit inv_it, input bit junk_it, output int acc_wait);
    logic [511:0] d;
    int wc0, fc0;
    d = rnd_line();
    do_miss(a, w, acc_wait);
    chk("busy_after_accept", 32'(busy), 1);
    wait_req(ref_line(a), rdly);
    if (kill_it) begin kill = 1'b1; step(); kill = 1'b0; end
    if (inv_it) do_inval(a);
    if (junk_it) begin
      wc0 = wr_cnt;
      if ($urandom_range(0, 1) == 0) send_rsp(RSP_FILL, ref_line(a) ^ 32'h200, rnd_line());
      else send_rsp(3'b100, ref_line(a), rnd_line());
      chk("junk_no_wr", 32'(arr_wr_en), 0);
      chk("junk_busy", 32'(busy), 1);
      step();
      chk("junk_wr_count", wr_cnt, wc0);
    end
    for (int i = 0; i < lat; i++) step();
    wc0 = wr_cnt; fc0 = fill_cnt;
    send_rsp(RSP_FILL, ref_line(a) + (a % 512), d);
    check_fill(a, w, d, !inv_it, !kill_it);
    step();
    chk("post_fill_busy", 32'(busy), 0);
    chk("post_fill_miss_ready", 32'(miss_ready), 1);
    chk("post_fill_pulse_low", 32'(fill_done), 0);
    chk("post_fill_wr_count", wr_cnt, wc0 + 1);
    chk("post_fill_done_count", fill_cnt, fc0 + 32'(!kill_it));
  endtask

  initial begin
    int acc;
    int n, wc0, fc0;
    logic [31:0] a;
    logic [511:0] d;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_miss_ready", 32'(miss_ready), 1);
    chk("rst_rsp_ready", 32'(l2_rsp_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_valid", 32'(l2_req_valid), 0);
    chk("rst_req_addr", l2_req_addr, 0);
    chk("rst_wr_en", 32'(arr_wr_en), 0);
    chk("rst_rd_en", 32'(arr_rd_en), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    step(); step();
    rst = 1'b1;
    step();

    // Basic miss, L2 ready after one cycle, FILL five cycles later
    full_miss(32'h0000_1040, 2'd2, 1, 5, 1'b0, 1'b0, 1'b0, acc);
    chk("basic_accept_wait", acc, 0);

    // Populate set of 0x2000: ways 1,3 with its tag, way 2 with a different tag
    full_miss(32'h0000_2000, 2'd1, 0, 2, 1'b0, 1'b0, 1'b0, acc);
    full_miss(32'h0000_2000, 2'd3, 0, 2, 1'b0, 1'b0, 1'b0, acc);
    full_miss(32'h0008_2000, 2'd2, 0, 2, 1'b0, 1'b0, 1'b0, acc);
    chk("inval_ref_mask", ref_mask(32'h0000_2000), 32'b1010);
    do_inval(32'h0000_2000);
    do_inval(32'h0000_2000);
    do_inval(32'h0008_2000);

    // Invalidate of the outstanding line poisons the fill
    full_miss(32'h0000_3000, 2'd0, 0, 3, 1'b0, 1'b1, 1'b0, acc);

    // Kill in WAIT, then the next miss is taken the cycle after FILL
    full_miss(32'h0001_4000, 2'd3, 0, 3, 1'b1, 1'b0, 1'b0, acc);
    full_miss(32'h0001_8000, 2'd1, 0, 1, 1'b0, 1'b0, 1'b0, acc);
    chk("accept_after_fill", acc, 0);

    // No response: request reissued after 256 WAIT cycles, late FILL completes
    a = 32'h0123_4567;
    d = rnd_line();
    do_miss(a, 2'd1, acc);
    wait_req(ref_line(a), 0);
    n = 0;
    while (!l2_req_valid && n < 400) begin step(); n++; end
    chk("timeout_wait_cycles", n, 256);
    chk("timeout_reissue_addr", l2_req_addr, ref_line(a));
    wait_req(ref_line(a), 0);
    wc0 = wr_cnt; fc0 = fill_cnt;
    send_rsp(RSP_FILL, ref_line(a), d);
    check_fill(a, 2'd1, d, 1'b1, 1'b1);
    step();
    chk("timeout_wr_count", wr_cnt, wc0 + 1);
    chk("timeout_done_count", fill_cnt, fc0 + 1);

    // Reset during WAIT drops the miss; the late FILL must not write
    a = 32'h0000_5200;
    do_miss(a, 2'd0, acc);
    wait_req(ref_line(a), 0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_miss_ready", 32'(miss_ready), 1);
    chk("midrst_rsp_ready", 32'(l2_rsp_ready), 1);
    step();
    rst = 1'b1;
    wc0 = wr_cnt; fc0 = fill_cnt;
    send_rsp(RSP_FILL, ref_line(a), rnd_line());
    chk("midrst_no_wr", 32'(arr_wr_en), 0);
    chk("midrst_no_done", 32'(fill_done), 0);
    step();
    step();
    chk("midrst_wr_count", wr_cnt, wc0);
    chk("midrst_done_count", fill_cnt, fc0);
    chk("midrst_idle", 32'(busy), 0);

    // Randomized misses with mixed latency, kills, invalidates and stray responses
    for (int i = 0; i < 16; i++) begin
      full_miss($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 10),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, acc);
      if ($urandom_range(0, 2) == 0) do_inval($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
